// File: rtl/spi_pkg.sv
// Shared SPI slave receiver types: mode encodings, FSM states and default frame width.
package spi_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    // Encoded as {cpol, cpha}, matching the SPI master.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_ABORT = 2'd3
    } spi_state_e;

    function automatic spi_mode_e mode_of(input logic cpol, input logic cpha);
        return spi_mode_e'({cpol, cpha});
    endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI bus plus tx/rx handshake bundle between the SPI slave and its user.
interface spi_slave_rx_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              cpol;
    logic              cpha;
    logic              sclk;
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  cpol, cpha, sclk, ss_n, mosi, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output cpol, cpha, sclk, ss_n, mosi, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall detection
// on the synchronized value.
module spi_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);
    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
        prev_d  = chain_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign q      = chain_q[STAGES-1];
    assign rise_c = chain_q[STAGES-1] & ~prev_q;
    assign fall_c = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave: receives frames on mosi, returns held tx bytes on miso, all four SPI modes.
// Define SPI_SLAVE_MSB_FIRST_EN to shift both directions MSB first (default LSB first).
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_slave_rx_if.slave         bus
);
    localparam int unsigned CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef SPI_SLAVE_MSB_FIRST_EN
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] sh, input logic b);
        return {sh[DATA_W-2:0], b};
    endfunction
    function automatic logic tx_bit(input logic [DATA_W-1:0] sh);
        return sh[DATA_W-1];
    endfunction
    function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] sh);
        return {sh[DATA_W-2:0], 1'b0};
    endfunction
`else
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] sh, input logic b);
        return {b, sh[DATA_W-1:1]};
    endfunction
    function automatic logic tx_bit(input logic [DATA_W-1:0] sh);
        return sh[0];
    endfunction
    function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] sh);
        return {1'b0, sh[DATA_W-1:1]};
    endfunction
`endif

    logic sclk_s, sclk_rise_c, sclk_fall_c;
    logic ss_s, ss_rise_c, ss_fall_c;
    logic mosi_s, mosi_rise_c, mosi_fall_c;
    logic unused_sync;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .reset(reset), .d(bus.sclk),
        .q(sclk_s), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk(clk), .reset(reset), .d(bus.ss_n),
        .q(ss_s), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .reset(reset), .d(bus.mosi),
        .q(mosi_s), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
    );

    assign unused_sync = ^{sclk_s, ss_rise_c, mosi_rise_c, mosi_fall_c};

    spi_state_e        state_q, state_d;
    spi_mode_e         mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              tx_ready_q, tx_ready_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              under_pend_q, under_pend_d;
    logic              busy_q, busy_d;

    logic              cpol_l, cpha_l;
    logic              lead_c, trail_c, sample_c, shift_c;
    logic              take_c;
    logic [DATA_W-1:0] next_byte_c;

    // Edge roles come from the mode latched at the start of the frame.
    assign cpol_l   = mode_q[1];
    assign cpha_l   = mode_q[0];
    assign lead_c   = cpol_l ? sclk_fall_c : sclk_rise_c;
    assign trail_c  = cpol_l ? sclk_rise_c : sclk_fall_c;
    assign sample_c = cpha_l ? trail_c : lead_c;
    assign shift_c  = cpha_l ? lead_c  : trail_c;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cnt_d         = cnt_q;
        rx_sh_d       = rx_sh_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_sh_d       = tx_sh_q;
        miso_d        = miso_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        tx_underrun_d = 1'b0;
        under_pend_d  = under_pend_q;
        take_c        = 1'b0;
        next_byte_c   = hold_full_q ? hold_q : '0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (ss_fall_c) begin
                    state_d = ST_LOAD;
                    mode_d  = mode_of(bus.cpol, bus.cpha);
                end
            end
            ST_LOAD: begin
                cnt_d        = '0;
                rx_sh_d      = '0;
                under_pend_d = 1'b0;
                if (ss_s) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else begin
                    state_d       = ST_SHIFT;
                    take_c        = 1'b1;
                    tx_underrun_d = ~hold_full_q;
                    // cpha=0 needs bit 0 on the wire before the first sample edge.
                    if (cpha_l) begin
                        tx_sh_d = next_byte_c;
                        miso_d  = 1'b0;
                    end else begin
                        tx_sh_d = tx_adv(next_byte_c);
                        miso_d  = tx_bit(next_byte_c);
                    end
                end
            end
            ST_SHIFT: begin
                if (ss_s) begin
                    state_d = (cnt_q != '0) ? ST_ABORT : ST_IDLE;
                    miso_d  = 1'b0;
                end else if (sample_c) begin
                    rx_sh_d = rx_shift(rx_sh_q, mosi_s);
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (under_pend_q) begin
                        tx_underrun_d = 1'b1;
                        under_pend_d  = 1'b0;
                    end
                    // Byte complete: publish it and reload tx for a back-to-back frame.
                    // An empty reload is only flagged once the next frame actually clocks.
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d    = rx_shift(rx_sh_q, mosi_s);
                        rx_valid_d   = 1'b1;
                        take_c       = 1'b1;
                        tx_sh_d      = next_byte_c;
                        under_pend_d = ~hold_full_q;
                    end
                end else if (shift_c) begin
                    miso_d  = tx_bit(tx_sh_q);
                    tx_sh_d = tx_adv(tx_sh_q);
                end
            end
            ST_ABORT: begin
                state_d      = ST_IDLE;
                miso_d       = 1'b0;
                cnt_d        = '0;
                rx_sh_d      = '0;
                under_pend_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // A load consumes the old holding contents; a same-cycle capture refills it.
        if (take_c) hold_full_d = 1'b0;
        if (bus.tx_valid && tx_ready_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
        tx_ready_d = ~hold_full_d;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE0;
            cnt_q         <= '0;
            rx_sh_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_sh_q       <= '0;
            miso_q        <= 1'b0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            tx_ready_q    <= 1'b1;
            tx_underrun_q <= 1'b0;
            under_pend_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            rx_sh_q       <= rx_sh_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_sh_q       <= tx_sh_d;
            miso_q        <= miso_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            tx_ready_q    <= tx_ready_d;
            tx_underrun_q <= tx_underrun_d;
            under_pend_q  <= under_pend_d;
            busy_q        <= busy_d;
        end
    end

    // miso is forced low the moment select deasserts or the FSM is idle.
    assign bus.miso        = miso_q & ~ss_s & (state_q != ST_IDLE);
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: SPI master model plus rx scoreboard.
module tb_spi_slave_rx;
    localparam int unsigned SYNC = 2;
`ifdef SPI_SLAVE_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_slave_rx_if #(.DATA_W(8)) bus ();

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int rx_pulses = 0;
    int n_underrun = 0;
    logic [7:0] exp_q[$];
    logic       bits_seen [8];

    // Scoreboard: each rx_valid pops one expected byte.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.rx_valid === 1'b1) begin
            rx_pulses++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rx_unexpected got=%h exp=none", bus.rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.rx_data !== e) begin
                    n_err++;
                    $display("FAIL rx_data got=%h exp=%h", bus.rx_data, e);
                end
            end
        end
        if (reset === 1'b0 && bus.tx_underrun === 1'b1) n_underrun++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [1:0] mode, input logic [7:0] mo, input bit first,
                            input bit last, input int nbits, output logic [7:0] mi);
        logic cpol, cpha;
        int   idx;
        cpol = mode[1];
        cpha = mode[0];
        mi   = '0;
        if (first) begin
            bus.cpol = cpol;
            bus.cpha = cpha;
            bus.sclk = cpol;
            repeat (8) @(negedge clk);
            bus.ss_n = 1'b0;
            half();
            bus.cpol = ~cpol;
            bus.cpha = ~cpha;
        end
        for (int i = 0; i < nbits; i++) begin
            idx = MSB ? 7 - i : i;
            if (!cpha) begin
                bus.mosi = mo[idx];
                half();
                mi[idx] = bus.miso;
                bits_seen[i] = bus.miso;
                bus.sclk = ~cpol;
                half();
                bus.sclk = cpol;
            end else begin
                half();
                bus.sclk = ~cpol;
                bus.mosi = mo[idx];
                half();
                mi[idx] = bus.miso;
                bits_seen[i] = bus.miso;
                bus.sclk = cpol;
            end
        end
        if (last) begin
            half();
            bus.ss_n = 1'b1;
            bus.mosi = 1'b0;
        end
    endtask

    task automatic load_tx(input logic [7:0] b);
        int t;
        t = 0;
        while (bus.tx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t >= 50) begin
            n_err++;
            $display("FAIL tx_ready_wait got=%b exp=1", bus.tx_ready);
        end
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        n_vec++;
        if (bus.tx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL tx_ready_after_load got=%b exp=0", bus.tx_ready);
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_rx got=%0d exp=0 pending", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check8("reset_miso", {7'd0, bus.miso}, 8'h00);
        check8("reset_rx_data", bus.rx_data, 8'h00);
        check8("reset_rx_valid", {7'd0, bus.rx_valid}, 8'h00);
        check8("reset_underrun", {7'd0, bus.tx_underrun}, 8'h00);
        check8("reset_busy", {7'd0, bus.busy}, 8'h00);
        check8("reset_tx_ready", {7'd0, bus.tx_ready}, 8'h01);
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [7:0] mi;
        logic       exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int         p0;
        load_tx(8'hA5);
        p0 = rx_pulses;
        exp_q.push_back(8'h3C);
        spi_byte(2'b00, 8'h3C, 1'b1, 1'b1, 8, mi);
        drain("mode0");
        check8("mode0_miso_byte", mi, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (bits_seen[i] !== exp_bits[i]) begin
                n_err++;
                $display("FAIL mode0_miso_bit%0d got=%b exp=%b", i, bits_seen[i], exp_bits[i]);
            end
        end
        check8("mode0_rx_pulses", 8'(rx_pulses - p0), 8'd1);
        check8("mode0_rx_data", bus.rx_data, 8'h3C);
        check8("mode0_busy_idle", {7'd0, bus.busy}, 8'h00);
        check8("mode0_miso_idle", {7'd0, bus.miso}, 8'h00);
    endtask

    task automatic test_modes();
        logic [7:0] mi;
        int         p0, u0;
        for (int m = 1; m < 4; m++) begin
            load_tx(8'h7E);
            p0 = rx_pulses;
            u0 = n_underrun;
            exp_q.push_back(8'h81);
            spi_byte(2'(m), 8'h81, 1'b1, 1'b1, 8, mi);
            drain("modes");
            check8($sformatf("mode%0d_miso_byte", m), mi, 8'h7E);
            check8($sformatf("mode%0d_underrun", m), 8'(n_underrun - u0), 8'd0);
            check8($sformatf("mode%0d_rx_pulses", m), 8'(rx_pulses - p0), 8'd1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi0, mi1;
        int         p0, u0;
        load_tx(8'h5A);
        p0 = rx_pulses;
        u0 = n_underrun;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        spi_byte(2'b00, 8'h01, 1'b1, 1'b0, 8, mi0);
        spi_byte(2'b00, 8'hFF, 1'b0, 1'b1, 8, mi1);
        drain("b2b");
        check8("b2b_miso_first", mi0, 8'h5A);
        check8("b2b_miso_second", mi1, 8'h00);
        check8("b2b_underrun", 8'(n_underrun - u0), 8'd1);
        check8("b2b_rx_pulses", 8'(rx_pulses - p0), 8'd2);
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        int         p0, k;
        load_tx(8'hC3);
        p0 = rx_pulses;
        spi_byte(2'b00, 8'hF0, 1'b1, 1'b0, 5, mi);
        half();
        bus.ss_n = 1'b1;
        check8("abort_busy_before", {7'd0, bus.busy}, 8'h01);
        k = 0;
        while (bus.busy !== 1'b0 && k < 12) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k > int'(SYNC) + 2 || k <= int'(SYNC)) begin
            n_err++;
            $display("FAIL abort_busy_fall got=%0d clk exp=%0d..%0d", k, SYNC + 1, SYNC + 2);
        end
        repeat (8) @(negedge clk);
        check8("abort_rx_pulses", 8'(rx_pulses - p0), 8'd0);
        check8("abort_rx_data_kept", bus.rx_data, 8'hFF);
        load_tx(8'h96);
        p0 = rx_pulses;
        exp_q.push_back(8'h69);
        spi_byte(2'b00, 8'h69, 1'b1, 1'b1, 8, mi);
        drain("after_abort");
        check8("after_abort_miso", mi, 8'h96);
        check8("after_abort_pulses", 8'(rx_pulses - p0), 8'd1);
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi;
        load_tx(8'h11);
        spi_byte(2'b00, 8'hAA, 1'b1, 1'b0, 3, mi);
        bus.mosi = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check8("rstmid_miso", {7'd0, bus.miso}, 8'h00);
        check8("rstmid_rx_data", bus.rx_data, 8'h00);
        check8("rstmid_rx_valid", {7'd0, bus.rx_valid}, 8'h00);
        check8("rstmid_underrun", {7'd0, bus.tx_underrun}, 8'h00);
        check8("rstmid_busy", {7'd0, bus.busy}, 8'h00);
        check8("rstmid_tx_ready", {7'd0, bus.tx_ready}, 8'h01);
        @(negedge clk);
        bus.sclk = 1'b0;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check8("rstmid_no_spurious_frame", {7'd0, bus.busy}, 8'h00);
        bus.ss_n = 1'b1;
        repeat (8) @(negedge clk);
        load_tx(8'hC5);
        exp_q.push_back(8'h55);
        spi_byte(2'b00, 8'h55, 1'b1, 1'b1, 8, mi);
        drain("rstmid");
        check8("rstmid_next_miso", mi, 8'hC5);
        check8("rstmid_next_rx_data", bus.rx_data, 8'h55);
    endtask

    task automatic test_bit_order();
        logic [7:0] mi;
        int         u0;
        u0 = n_underrun;
        exp_q.push_back(8'h01);
        spi_byte(2'b00, 8'h01, 1'b1, 1'b1, 8, mi);
        drain("order01");
        check8("order01_miso_empty", mi, 8'h00);
        exp_q.push_back(8'h80);
        spi_byte(2'b11, 8'h80, 1'b1, 1'b1, 8, mi);
        drain("order80");
        check8("order80_miso_empty", mi, 8'h00);
        check8("order_underruns", 8'(n_underrun - u0), 8'd2);
    endtask

    initial begin
        reset        = 1'b1;
        bus.cpol     = 1'b0;
        bus.cpha     = 1'b0;
        bus.sclk     = 1'b0;
        bus.ss_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_bit_order();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
